matmul_acc: RTL
===============

// Module: matmul_acc
// PURPOSE
//  Memory-mapped matrix engine: C = A*B (MODE_ACC=0) or C = C + A*B (MODE_ACC=1).
//  Matrices live row-major in a shared single-port memory with per-matrix stride.
//  Unlike the first-generation engine, reads are latency-tolerant: it waits for mem_rdata_vld.
//  Adds accumulate mode, a busy flag and an optional saturating accumulator.
//  Sits beside the CPU on the memory fabric; started by go, done signalled by ret.
// PARAMETERS
//  MEM_AW    16  memory address width (word addressed)
//  MEM_DW    32  memory data width; accumulator width
//  DIM_BITS  16  width of dimension/stride inputs
//  PREC      16  operand precision, unsigned, taken from mem_rdata[PREC-1:0]; PREC*2 <= MEM_DW
// PORTS
//  clk            in   1         clock, rising edge
//  rst_n          in   1         asynchronous active-low reset
//  go             in   1         start request, sampled in IDLE
//  mode_acc       in   1         0: C=A*B, 1: C+=A*B; sampled with go
//  ret            out  1         one-cycle done pulse
//  busy           out  1         high from go accept until ret cycle inclusive
//  aBASE,bBASE,cBASE     in MEM_AW    matrix base addresses
//  aSTRIDE,bSTRIDE,cSTRIDE in DIM_BITS row strides (words)
//  aROWS,aCOLS,bCOLS     in DIM_BITS  dims: A is aROWS x aCOLS, B is aCOLS x bCOLS
//  mem_req        out  1         memory request
//  mem_write      out  1         1 write, 0 read
//  mem_addr       out  MEM_AW    request address
//  mem_wdata      out  MEM_DW    write data
//  mem_rdata_vld  in   1         read data valid (completes the pending read)
//  mem_rdata      in   MEM_DW    read data
// BEHAVIOUR
//  - Reset: ret,busy,mem_req,mem_write=0; mem_addr,mem_wdata=0; all counters/acc=0; state IDLE.
//  - Memory handshake: mem_req/mem_write/mem_addr held stable until completion. Read completes
//    in the cycle mem_rdata_vld=1 (data captured that edge); write completes after 1 cycle.
//    mem_req drops for >=1 cycle between requests. mem_rdata_vld while no read pending: ignored.
//  - Config inputs are sampled into internal registers when go is accepted; later changes ignored.
//  - FSM: IDLE -> ROW -> COL -> [RD_C if mode_acc] -> RD_A -> RD_B -> MAC ... -> WR_C -> COL/ROW -> DONE -> IDLE.
//    IDLE: go=1 -> latch config, i=0, busy=1, -> ROW.
//    ROW: i==aROWS -> DONE; else j=0, c_ij=c_i0, b_0j=bBASE -> COL.
//    COL: j==bCOLS -> a_i0+=aSTRIDE, c_i0+=cSTRIDE, i++ -> ROW; else k=0, acc=0, -> RD_C or RD_A.
//    RD_C: read c_ij, acc=mem_rdata on completion.
//    RD_A: k==aCOLS -> WR_C; else read a_ik, latch a, a_ik++.
//    RD_B: read b_kj, b_kj+=bSTRIDE -> MAC. MAC: acc+=a*b[PREC-1:0], k++ -> RD_A.
//    WR_C: write acc to c_ij; c_ij++, b_0j++, j++ -> COL.
//    DONE: ret=1, busy=0 next cycle -> IDLE.
//  - Arithmetic: product 2*PREC bits, zero-extended to MEM_DW; acc wraps mod 2^MEM_DW.
//    Address arithmetic wraps mod 2^MEM_AW.
//  - Boundaries: aROWS==0 or bCOLS==0 -> no memory traffic, ret 2-3 cycles after go.
//    aCOLS==0 -> each C element written as 0 (mode 0) or its prior value (mode 1).
//    go while busy: ignored. go held high after DONE: new run starts (back-to-back legal).
//    rst_n low mid-run: immediate abort, mem_req=0, pending read discarded, no ret.
// CONFIGURATION
//  MATMUL_ACC_SAT_EN defined: acc add saturates at 2^MEM_DW-1 (sticky until WR_C).
//  Not defined: acc wraps modulo 2^MEM_DW. Port list identical in both builds.
// TESTING
//  - 2x2 A=[1,2;3,4], B=[5,6;7,8], mode 0, vld 1 cycle after req -> C=[19,22;43,50], one ret.
//  - Same, mode_acc=1, C preloaded [1,1;1,1] -> C=[20,23;44,51].
//  - Random read latency 1..8 cycles, 3x4 * 4x2 with strides > cols -> match model, addr stable while pending.
//  - aROWS=0 -> zero mem_req, ret within 3 cycles; aCOLS=0 mode0 -> C all 0.
//  - A=B=0xFFFF, aCOLS=4, MEM_DW=32: SAT_EN -> C=0xFFFFFFFF; else C=0xFFF80004.
//  - rst_n asserted mid RD_B -> outputs 0 immediately; new go runs cleanly with correct C.

Source files
------------

// File: rtl/matmul_acc_if.sv
// Memory fabric port of the matrix engine: one request channel plus read-data return.
interface matmul_acc_if #(
    parameter int MEM_AW = 16,
    parameter int MEM_DW = 32
);
    logic              mem_req;
    logic              mem_write;
    logic [MEM_AW-1:0] mem_addr;
    logic [MEM_DW-1:0] mem_wdata;
    logic              mem_rdata_vld;
    logic [MEM_DW-1:0] mem_rdata;

    modport master (
        output mem_req, mem_write, mem_addr, mem_wdata,
        input  mem_rdata_vld, mem_rdata
    );

    modport slave (
        input  mem_req, mem_write, mem_addr, mem_wdata,
        output mem_rdata_vld, mem_rdata
    );
endinterface

// File: rtl/matmul_acc.sv
// Memory-mapped C = A*B / C += A*B engine with latency-tolerant reads.
// Build option MATMUL_ACC_SAT_EN: accumulator saturates instead of wrapping.
//
// state | meaning
// IDLE  | waiting for go, config latched on accept
// ROW   | start row i of C (or finish)
// COL   | start element (i,j) of C (or advance row)
// RD_C  | read prior C element into acc (accumulate mode)
// RD_A  | read a_ik, or go write once k reaches aCOLS
// RD_B  | read b_kj
// MAC   | acc += a*b
// WR_C  | write acc to c_ij
// DONE  | one-cycle ret pulse
module matmul_acc #(
    parameter int MEM_AW   = 16,
    parameter int MEM_DW   = 32,
    parameter int DIM_BITS = 16,
    parameter int PREC     = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                go,
    input  logic                mode_acc,
    output logic                ret,
    output logic                busy,
    input  logic [MEM_AW-1:0]   aBASE,
    input  logic [MEM_AW-1:0]   bBASE,
    input  logic [MEM_AW-1:0]   cBASE,
    input  logic [DIM_BITS-1:0] aSTRIDE,
    input  logic [DIM_BITS-1:0] bSTRIDE,
    input  logic [DIM_BITS-1:0] cSTRIDE,
    input  logic [DIM_BITS-1:0] aROWS,
    input  logic [DIM_BITS-1:0] aCOLS,
    input  logic [DIM_BITS-1:0] bCOLS,
    matmul_acc_if.master        mem
);

    localparam logic [3:0] S_IDLE = 4'd0;
    localparam logic [3:0] S_ROW  = 4'd1;
    localparam logic [3:0] S_COL  = 4'd2;
    localparam logic [3:0] S_RD_C = 4'd3;
    localparam logic [3:0] S_RD_A = 4'd4;
    localparam logic [3:0] S_RD_B = 4'd5;
    localparam logic [3:0] S_MAC  = 4'd6;
    localparam logic [3:0] S_WR_C = 4'd7;
    localparam logic [3:0] S_DONE = 4'd8;

    logic [3:0]          state_q, state_d;
    logic                req_q, req_d, wr_q, wr_d;
    logic [MEM_AW-1:0]   addr_q, addr_d;
    logic [MEM_DW-1:0]   wdata_q, wdata_d;
    logic                mode_q, mode_d;
    logic [DIM_BITS-1:0] arows_q, arows_d, acols_q, acols_d, bcols_q, bcols_d;
    logic [DIM_BITS-1:0] astride_q, astride_d, bstride_q, bstride_d, cstride_q, cstride_d;
    logic [MEM_AW-1:0]   bbase_q, bbase_d;
    logic [MEM_AW-1:0]   a_i0_q, a_i0_d, a_ik_q, a_ik_d;
    logic [MEM_AW-1:0]   b_0j_q, b_0j_d, b_kj_q, b_kj_d;
    logic [MEM_AW-1:0]   c_i0_q, c_i0_d, c_ij_q, c_ij_d;
    logic [DIM_BITS-1:0] i_q, i_d, j_q, j_d, k_q, k_d;
    logic [MEM_DW-1:0]   acc_q, acc_d;
    logic [PREC-1:0]     a_op_q, a_op_d, b_op_q, b_op_d;

    logic [2*PREC-1:0]   prod;
    logic [MEM_DW-1:0]   prod_ext;
    logic [MEM_DW-1:0]   acc_mac;

    assign prod     = {{PREC{1'b0}}, a_op_q} * {{PREC{1'b0}}, b_op_q};
    assign prod_ext = MEM_DW'(prod);

`ifdef MATMUL_ACC_SAT_EN
    logic [MEM_DW:0] sum_full;
    assign sum_full = {1'b0, acc_q} + {1'b0, prod_ext};
    // Once pinned at all-ones further (non-negative) adds keep it there.
    assign acc_mac  = sum_full[MEM_DW] ? {MEM_DW{1'b1}} : sum_full[MEM_DW-1:0];
`else
    assign acc_mac  = acc_q + prod_ext;
`endif

    assign ret           = (state_q == S_DONE);
    assign busy          = (state_q != S_IDLE);
    assign mem.mem_req   = req_q;
    assign mem.mem_write = wr_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = wdata_q;

    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        wr_d      = wr_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        mode_d    = mode_q;
        arows_d   = arows_q;
        acols_d   = acols_q;
        bcols_d   = bcols_q;
        astride_d = astride_q;
        bstride_d = bstride_q;
        cstride_d = cstride_q;
        bbase_d   = bbase_q;
        a_i0_d    = a_i0_q;
        a_ik_d    = a_ik_q;
        b_0j_d    = b_0j_q;
        b_kj_d    = b_kj_q;
        c_i0_d    = c_i0_q;
        c_ij_d    = c_ij_q;
        i_d       = i_q;
        j_d       = j_q;
        k_d       = k_q;
        acc_d     = acc_q;
        a_op_d    = a_op_q;
        b_op_d    = b_op_q;

        // Each memory state raises req in its first cycle and drops it on completion,
        // so the next state's first cycle is the mandatory idle gap on the bus.
        case (state_q)
            S_IDLE: begin
                if (go) begin
                    mode_d    = mode_acc;
                    arows_d   = aROWS;
                    acols_d   = aCOLS;
                    bcols_d   = bCOLS;
                    astride_d = aSTRIDE;
                    bstride_d = bSTRIDE;
                    cstride_d = cSTRIDE;
                    bbase_d   = bBASE;
                    a_i0_d    = aBASE;
                    c_i0_d    = cBASE;
                    i_d       = '0;
                    state_d   = S_ROW;
                end
            end
            S_ROW: begin
                if (i_q == arows_q || bcols_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    j_d     = '0;
                    c_ij_d  = c_i0_q;
                    b_0j_d  = bbase_q;
                    state_d = S_COL;
                end
            end
            S_COL: begin
                if (j_q == bcols_q) begin
                    a_i0_d  = a_i0_q + MEM_AW'(astride_q);
                    c_i0_d  = c_i0_q + MEM_AW'(cstride_q);
                    i_d     = i_q + DIM_BITS'(1);
                    state_d = S_ROW;
                end else begin
                    k_d     = '0;
                    acc_d   = '0;
                    a_ik_d  = a_i0_q;
                    b_kj_d  = b_0j_q;
                    state_d = mode_q ? S_RD_C : S_RD_A;
                end
            end
            S_RD_C: begin
                if (!req_q) begin
                    req_d  = 1'b1;
                    addr_d = c_ij_q;
                end else if (mem.mem_rdata_vld) begin
                    acc_d   = mem.mem_rdata;
                    req_d   = 1'b0;
                    state_d = S_RD_A;
                end
            end
            S_RD_A: begin
                if (!req_q) begin
                    if (k_q == acols_q) begin
                        state_d = S_WR_C;
                    end else begin
                        req_d  = 1'b1;
                        addr_d = a_ik_q;
                    end
                end else if (mem.mem_rdata_vld) begin
                    a_op_d  = mem.mem_rdata[PREC-1:0];
                    a_ik_d  = a_ik_q + MEM_AW'(1);
                    req_d   = 1'b0;
                    state_d = S_RD_B;
                end
            end
            S_RD_B: begin
                if (!req_q) begin
                    req_d  = 1'b1;
                    addr_d = b_kj_q;
                end else if (mem.mem_rdata_vld) begin
                    b_op_d  = mem.mem_rdata[PREC-1:0];
                    b_kj_d  = b_kj_q + MEM_AW'(bstride_q);
                    req_d   = 1'b0;
                    state_d = S_MAC;
                end
            end
            S_MAC: begin
                acc_d   = acc_mac;
                k_d     = k_q + DIM_BITS'(1);
                state_d = S_RD_A;
            end
            S_WR_C: begin
                if (!req_q) begin
                    req_d   = 1'b1;
                    wr_d    = 1'b1;
                    addr_d  = c_ij_q;
                    wdata_d = acc_q;
                end else begin
                    req_d   = 1'b0;
                    wr_d    = 1'b0;
                    c_ij_d  = c_ij_q + MEM_AW'(1);
                    b_0j_d  = b_0j_q + MEM_AW'(1);
                    j_d     = j_q + DIM_BITS'(1);
                    state_d = S_COL;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            req_q     <= 1'b0;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            mode_q    <= 1'b0;
            arows_q   <= '0;
            acols_q   <= '0;
            bcols_q   <= '0;
            astride_q <= '0;
            bstride_q <= '0;
            cstride_q <= '0;
            bbase_q   <= '0;
            a_i0_q    <= '0;
            a_ik_q    <= '0;
            b_0j_q    <= '0;
            b_kj_q    <= '0;
            c_i0_q    <= '0;
            c_ij_q    <= '0;
            i_q       <= '0;
            j_q       <= '0;
            k_q       <= '0;
            acc_q     <= '0;
            a_op_q    <= '0;
            b_op_q    <= '0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            wr_q      <= wr_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            mode_q    <= mode_d;
            arows_q   <= arows_d;
            acols_q   <= acols_d;
            bcols_q   <= bcols_d;
            astride_q <= astride_d;
            bstride_q <= bstride_d;
            cstride_q <= cstride_d;
            bbase_q   <= bbase_d;
            a_i0_q    <= a_i0_d;
            a_ik_q    <= a_ik_d;
            b_0j_q    <= b_0j_d;
            b_kj_q    <= b_kj_d;
            c_i0_q    <= c_i0_d;
            c_ij_q    <= c_ij_d;
            i_q       <= i_d;
            j_q       <= j_d;
            k_q       <= k_d;
            acc_q     <= acc_d;
            a_op_q    <= a_op_d;
            b_op_q    <= b_op_d;
        end
    end

endmodule
